btn_bounce_gen: RTL and testbench

Synthesizable bouncy-button emulator: turns a clean logical request level into an active-low, contact-bounce-shaped button signal with pseudo-random bounce spacing. It drives the `nbtn` input of the button debouncer, so debouncer behaviour can be exercised on the board and in benches without a physical switch. Bounce timing comes from an internal LFSR, so a given SEED always produces the same waveform.

---
 rtl/btn_bounce_gen_if.sv | 10 +
 rtl/btn_bounce_gen.sv | 121 ++++++++++++
 tb/tb_btn_bounce_gen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_bounce_gen_if.sv
// Button-emulator bundle: logical request in, emulated active-low button and status out.
interface btn_bounce_gen_if;
  logic req;
  logic nbtn;
  logic busy;
  logic done;

  modport master (output req, input nbtn, input busy, input done);
  modport slave  (input req, output nbtn, output busy, output done);
endinterface

// File: rtl/btn_bounce_gen.sv
// Bouncy-button emulator: turns a clean req level into an active-low, contact-bounce
// shaped nbtn waveform whose edge spacing comes from a seeded 16-bit Galois LFSR.
module btn_bounce_gen #(
  parameter int          NUM_BOUNCES   = 20,
  parameter int          GAP_BITS      = 2,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic             clk,
  input  logic             nrst,
  btn_bounce_gen_if.slave  bus
);

  localparam int TW = $clog2(2 * NUM_BOUNCES + 2);
  localparam int GW = GAP_BITS + 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [15:0]   SEED_EFF    = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]   GAP_MASK    = 16'((32'd1 << GAP_BITS) - 32'd1);
  localparam logic [TW-1:0] LAST_TOG    = TW'(2 * NUM_BOUNCES);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

  state_t        r_state,      w_state_nxt;
  logic          r_level,      w_level_nxt;
  logic          r_busy,       w_busy_nxt;
  logic          r_done,       w_done_nxt;
  logic [15:0]   r_lfsr,       w_lfsr_nxt;
  logic [TW-1:0] r_tog_cnt,    w_tog_nxt;
  logic [GW-1:0] r_gap_cnt,    w_gap_nxt;
  logic [SW-1:0] r_settle_cnt, w_settle_nxt;
  logic [15:0]   w_lfsr_adv;

  // Gap in cycles until the next toggle: low GAP_BITS of the LFSR plus one.
  function automatic logic [GW-1:0] gap_of(input logic [15:0] l);
    return GW'(l & GAP_MASK) + GW'(1);
  endfunction

  assign w_lfsr_adv = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_level_nxt  = r_level;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_lfsr_nxt   = r_lfsr;
    w_tog_nxt    = r_tog_cnt;
    w_gap_nxt    = r_gap_cnt;
    w_settle_nxt = r_settle_cnt;

    unique case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (bus.req != r_level) begin
          w_tog_nxt   = '0;
          w_gap_nxt   = gap_of(r_lfsr);
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_BOUNCE;
        end
      end

      S_BOUNCE: begin
        if (r_gap_cnt == GW'(1)) begin
          // The first toggle lands on the target; later ones alternate away and back.
          w_level_nxt = ~r_level;
          w_tog_nxt   = r_tog_cnt + TW'(1);
          w_lfsr_nxt  = w_lfsr_adv;
          w_gap_nxt   = gap_of(w_lfsr_adv);
          if (r_tog_cnt == LAST_TOG) begin
            w_settle_nxt = SETTLE_INIT;
            w_state_nxt  = S_SETTLE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt - GW'(1);
        end
      end

      S_SETTLE: begin
        if (r_settle_cnt == SW'(1)) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_settle_nxt = r_settle_cnt - SW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= S_IDLE;
      r_level      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lfsr       <= SEED_EFF;
      r_tog_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_level      <= w_level_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_tog_cnt    <= w_tog_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  assign bus.nbtn = ~r_level;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Scoreboard bench for btn_bounce_gen: three parameterisations, model-predicted
// edge/done events queued at stimulus time and popped by an independent monitor.
module tb_btn_bounce_gen;

  localparam logic [15:0] TB_SEED = 16'hACE1;

  typedef enum {EV_TOG, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    logic     val;
  } ev_t;

  logic clk;
  logic rst_ac;
  logic rst_b;
  int   cyc;
  int   total;
  int   bad;

  btn_bounce_gen_if if_a ();
  btn_bounce_gen_if if_b ();
  btn_bounce_gen_if if_c ();

  btn_bounce_gen #(.NUM_BOUNCES(2),  .GAP_BITS(0), .SETTLE_CYCLES(3),  .SEED(TB_SEED))
    u_dut_a (.clk(clk), .nrst(rst_ac), .bus(if_a));
  btn_bounce_gen #(.NUM_BOUNCES(20), .GAP_BITS(2), .SETTLE_CYCLES(16), .SEED(TB_SEED))
    u_dut_b (.clk(clk), .nrst(rst_b),  .bus(if_b));
  btn_bounce_gen #(.NUM_BOUNCES(0),  .GAP_BITS(2), .SETTLE_CYCLES(4),  .SEED(TB_SEED))
    u_dut_c (.clk(clk), .nrst(rst_ac), .bus(if_c));

  logic [2:0] nbtn_v, busy_v, done_v, rst_v;
  assign nbtn_v = {if_c.nbtn, if_b.nbtn, if_a.nbtn};
  assign busy_v = {if_c.busy, if_b.busy, if_a.busy};
  assign done_v = {if_c.done, if_b.done, if_a.done};
  assign rst_v  = {rst_ac, rst_b, rst_ac};

  function automatic int nb(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 20 : 0);
  endfunction
  function automatic int gb(input int d);
    return (d == 0) ? 0 : 2;
  endfunction
  function automatic int st(input int d);
    return (d == 0) ? 3 : ((d == 1) ? 16 : 4);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  ev_t        sb [3][$];
  logic [15:0] m_lfsr [3];
  logic        m_level [3];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    int n;
    n = int'(l) / 2;
    if ((int'(l) % 2) == 1) n = n ^ 32'hB400;
    return n[15:0];
  endfunction

  function automatic int gap_of(input int d, input logic [15:0] l);
    return (int'(l) % (1 << gb(d))) + 1;
  endfunction

  // Predict every nbtn edge and the done pulse of one burst starting at edge e0.
  task automatic plan_burst(input int d, input int e0, input logic tgt, output int dc);
    int t;
    t = e0;
    for (int k = 1; k <= 2 * nb(d) + 1; k++) begin
      t += gap_of(d, m_lfsr[d]);
      m_lfsr[d] = lfsr_step(m_lfsr[d]);
      sb[d].push_back('{kind: EV_TOG, cyc: t, val: ((k % 2) == 1) ? ~tgt : tgt});
    end
    dc = t + st(d);
    sb[d].push_back('{kind: EV_DONE, cyc: dc, val: 1'b0});
    m_level[d] = tgt;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name, input int d);
    total++;
    bad++;
    $display("FAIL %s: dut %0d produced an event the model did not predict (cycle %0d)", name, d, cyc);
  endtask

  // ---------------- monitor ----------------
  logic prev [3] = '{1'b1, 1'b1, 1'b1};
  int   tog_n [3] = '{0, 0, 0};
  int   last_edge [3] = '{0, 0, 0};
  ev_t  mon_ev;
  int   db_cnt = 0;
  logic db_out = 1'b0;
  int   db_changes = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_v[d]) begin
        prev[d]  = nbtn_v[d];
        tog_n[d] = 0;
      end else begin
        if (nbtn_v[d] !== prev[d]) begin
          if (sb[d].size() == 0) miss("edge_unexpected", d);
          else begin
            mon_ev = sb[d].pop_front();
            if (mon_ev.kind != EV_TOG) miss("edge_before_done", d);
            else begin
              check("edge_cyc", cyc, mon_ev.cyc);
              check("edge_val", int'(nbtn_v[d]), int'(mon_ev.val));
            end
          end
          if (tog_n[d] > 0)
            check("edge_spacing_in_range",
                  int'((cyc - last_edge[d]) >= 1 && (cyc - last_edge[d]) <= (1 << gb(d))), 1);
          tog_n[d]++;
          last_edge[d] = cyc;
          prev[d] = nbtn_v[d];
        end
        if (done_v[d]) begin
          if (sb[d].size() == 0) miss("done_unexpected", d);
          else begin
            mon_ev = sb[d].pop_front();
            if (mon_ev.kind != EV_DONE) miss("done_before_edges", d);
            else check("done_cyc", cyc, mon_ev.cyc);
          end
          check("burst_toggle_count", tog_n[d], 2 * nb(d) + 1);
          tog_n[d] = 0;
        end
      end
    end
    // Behavioural debouncer (20 stable cycles) listening to instance B.
    if (!rst_b) begin
      db_cnt = 0;
      db_out = 1'b0;
      db_changes = 0;
    end else if (~if_b.nbtn != db_out) begin
      db_cnt++;
      if (db_cnt == 20) begin
        db_out = ~if_b.nbtn;
        db_cnt = 0;
        db_changes++;
      end
    end else begin
      db_cnt = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input logic v);
    case (d)
      0:       if_a.req = v;
      1:       if_b.req = v;
      default: if_c.req = v;
    endcase
  endtask

  // Drive req right after an edge; a burst, if any, starts on the next edge.
  task automatic issue(input int d, input logic v, output int e0, output int dc);
    set_req(d, v);
    e0 = cyc + 1;
    dc = -1;
    if (v != m_level[d]) plan_burst(d, e0, v, dc);
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n;
    n = 0;
    tick();
    while (!(sb[d].size() == 0 && !busy_v[d] && !done_v[d]) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL wait_idle: dut %0d still busy after %0d cycles, %0d events pending",
               d, budget, sb[d].size());
    end
  endtask

  task automatic busy_window(input int d, input int e0, input int dc);
    repeat (dc - e0 + 2) begin
      @(negedge clk);
      check("busy_window", int'(busy_v[d]), int'(cyc >= e0 && cyc < dc));
    end
  endtask

  task automatic reset_b_model();
    sb[1].delete();
    m_lfsr[1]  = TB_SEED;
    m_level[1] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, dc, n;
    total = 0;
    bad   = 0;
    if_a.req = 1'b0;
    if_b.req = 1'b0;
    if_c.req = 1'b0;
    rst_ac = 1'b0;
    rst_b  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      m_lfsr[d]  = TB_SEED;
      m_level[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check("reset_nbtn", int'(nbtn_v[d]), 1);
      check("reset_busy", int'(busy_v[d]), 0);
      check("reset_done", int'(done_v[d]), 0);
    end
    rst_ac = 1'b1;
    rst_b  = 1'b1;
    repeat (2) tick();

    // Deterministic press and release, then req glitches during a burst.
    issue(0, 1'b1, e0, dc);
    busy_window(0, e0, dc);
    wait_idle(0, 50);
    issue(0, 1'b0, e0, dc);
    busy_window(0, e0, dc);
    wait_idle(0, 50);

    issue(0, 1'b1, e0, dc);
    repeat ($urandom_range(1, 2)) tick();
    set_req(0, 1'b0);
    tick();
    set_req(0, 1'b1);
    wait_idle(0, 50);
    repeat (6) begin
      tick();
      check("no_burst_after_glitch", int'(busy_v[0]), 0);
    end

    issue(0, 1'b0, e0, dc);
    plan_burst(0, dc + 1, 1'b1, n);
    repeat ($urandom_range(1, 3)) tick();
    set_req(0, 1'b1);
    wait_idle(0, 80);
    issue(0, 1'b0, e0, dc);
    wait_idle(0, 50);

    // Single-edge instance with random request levels and idle gaps.
    repeat (8) begin
      repeat ($urandom_range(0, 3)) tick();
      issue(2, 1'(($urandom() >> 3) & 1), e0, dc);
      wait_idle(2, 50);
    end

    // Random-gap instance: reset mid-burst after seven toggles, then replay.
    issue(1, 1'b1, e0, dc);
    n = 0;
    while (tog_n[1] < 7 && n < 200) begin
      tick();
      n++;
    end
    check("reached_seven_toggles", int'(tog_n[1] >= 7), 1);
    rst_b = 1'b0;
    set_req(1, 1'b0);
    reset_b_model();
    #1;
    check("midburst_reset_nbtn", int'(if_b.nbtn), 1);
    check("midburst_reset_busy", int'(if_b.busy), 0);
    check("midburst_reset_done", int'(if_b.done), 0);
    repeat (2) tick();
    rst_b = 1'b1;
    tick();

    issue(1, 1'b1, e0, dc);
    wait_idle(1, 400);
    repeat (10) tick();
    check("debounced_changes_after_press", db_changes, 1);
    issue(1, 1'b0, e0, dc);
    wait_idle(1, 400);
    repeat (10) tick();
    check("debounced_changes_after_release", db_changes, 2);

    for (int d = 0; d < 3; d++) check("scoreboard_drained", sb[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
